// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM encoding, key indices and output codes for the key debouncer.
package key_pkg;
  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK} key_state_e;
  localparam int KEY_INC = 1;
  localparam int KEY_DEC = 0;
  localparam logic [1:0] KEY_CODE_INC = 2'b10;
  localparam logic [1:0] KEY_CODE_DEC = 2'b01;
  localparam logic [1:0] KEY_CODE_NONE = 2'b00;
  function automatic int unsigned cnt_w(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m);
  endfunction
endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw button inputs and debounced level/pulse outputs of the key debouncer.
interface key_debounce_if;
  logic [1:0] Key_In;
  logic [1:0] Key_Level;
  logic [1:0] Key_Out;
  modport master (output Key_In, input Key_Level, input Key_Out);
  modport slave (input Key_In, output Key_Level, output Key_Out);
endinterface

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: synchroniser, debounce FSM and auto-repeat counter for one active-low key.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic req_o
);
  localparam int unsigned W = cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  // The entry edge counts as the first stable sample, so debounce ends at D-2.
  localparam logic [W-1:0] DB_END = W'(DEBOUNCE_CYCLES - 2);
  localparam logic [W-1:0] RD_END = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] RP_END = W'(REPEAT_PERIOD - 1);
  logic [1:0] sync_q;
  key_state_e state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, cnt_inc;
  logic rep_q, rep_d, req_q, req_d, s;
  assign s = ~sync_q[1];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      rep_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      rep_q <= rep_d;
      req_q <= req_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rep_d = rep_q;
    req_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = s ? PRESS_CHK : IDLE;
        cnt_d = '0;
      end
      PRESS_CHK:
        if (!s) state_d = IDLE;
        else if (cnt_q == DB_END) begin
          state_d = HELD;
          cnt_d = '0;
          rep_d = 1'b0;
          req_d = 1'b1;
        end else cnt_d = cnt_inc;
      HELD, REPEAT:
        if (!s) begin
          state_d = REL_CHK;
          cnt_d = '0;
          rep_d = (state_q == REPEAT);
        end else if (REPEAT_EN) begin
          if (cnt_q == ((state_q == HELD) ? RD_END : RP_END)) begin
            state_d = REPEAT;
            cnt_d = '0;
            req_d = 1'b1;
          end else cnt_d = cnt_inc;
        end
      REL_CHK:
        if (s) begin
          state_d = rep_q ? REPEAT : HELD;
          cnt_d = '0;
        end else if (cnt_q == DB_END) begin
          state_d = IDLE;
          cnt_d = '0;
        end else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
  end
  always_comb level_o = (state_q == HELD) || (state_q == REPEAT) || (state_q == REL_CHK);
  assign req_o = req_q;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: two debounced keys with auto-repeat, merged into exclusive one-cycle press pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter bit REPEAT_EN = 1'b1
) (
  input logic Sys_CLK,
  input logic Sys_RST,
  key_debounce_if.slave kb
);
  logic [1:0] level, req, out_q, out_d, lvl_q;
  for (genvar i = 0; i < 2; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN(REPEAT_EN)
    ) u_chan (
      .clk(Sys_CLK),
      .rst(Sys_RST),
      .key_n_i(kb.Key_In[i]),
      .level_o(level[i]),
      .req_o(req[i])
    );
  end
  // A pulse is always followed by an idle cycle; requests landing in that gap are dropped.
  always_comb
    out_d = (out_q != KEY_CODE_NONE) ? KEY_CODE_NONE :
            (req[KEY_INC] & ~req[KEY_DEC]) ? KEY_CODE_INC :
            (req[KEY_DEC] & ~req[KEY_INC]) ? KEY_CODE_DEC : KEY_CODE_NONE;
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      out_q <= KEY_CODE_NONE;
      lvl_q <= 2'b00;
    end else begin
      out_q <= out_d;
      lvl_q <= level;
    end
  end
  assign kb.Key_Out = out_q;
  assign kb.Key_Level = lvl_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: checks a repeating and a single-shot debouncer against a run-length reference model.
module tb_key_debounce;
  localparam int D = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] kin = 2'b11;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  key_debounce_if ia ();
  key_debounce_if ib ();
  assign ia.Key_In = kin;
  assign ib.Key_In = kin;
  key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1))
    dut_a (.Sys_CLK(clk), .Sys_RST(rst), .kb(ia));
  key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0))
    dut_b (.Sys_CLK(clk), .Sys_RST(rst), .kb(ib));
  // Reference model, index 0 = repeat enabled (dut_a), 1 = single-shot (dut_b).
  logic [1:0] mh0[2], mh1[2], mlvl[2], mrep[2], mgl[2], mprq[2], mplv[2], eout[2], elvl[2];
  int mrun[2][2], mk[2][2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic model_step(input logic [1:0] k, input logic r);
    for (int j = 0; j < 2; j++) begin
      eout[j] = (r || eout[j] != 2'b00) ? 2'b00 : (mprq[j] == 2'b10 || mprq[j] == 2'b01) ? mprq[j] : 2'b00;
      elvl[j] = r ? 2'b00 : mplv[j];
      if (r) begin
        {mh0[j], mh1[j], mlvl[j], mrep[j], mgl[j], mprq[j], mplv[j]} = '0;
        for (int i = 0; i < 2; i++) begin
          mrun[j][i] = 0;
          mk[j][i] = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          logic s, q, acc;
          s = mh1[j][i];
          mh1[j][i] = mh0[j][i];
          mh0[j][i] = ~k[i];
          q = 1'b0;
          acc = 1'b0;
          if (s != mlvl[j][i]) begin
            mrun[j][i]++;
            if (mrun[j][i] == D) begin
              mlvl[j][i] = s;
              mrun[j][i] = 0;
              if (s) begin
                q = 1'b1;
                acc = 1'b1;
                mk[j][i] = 0;
                mrep[j][i] = 1'b0;
                mgl[j][i] = 1'b0;
              end
            end
          end else mrun[j][i] = 0;
          if (mlvl[j][i] && !acc) begin
            if (!s) begin
              mgl[j][i] = 1'b1;
              mk[j][i] = 0;
            end else if (mgl[j][i]) begin
              mgl[j][i] = 1'b0;
              mk[j][i] = 0;
            end else if (j == 0) begin
              mk[j][i]++;
              if (mk[j][i] == (mrep[j][i] ? RP : RD)) begin
                q = 1'b1;
                mrep[j][i] = 1'b1;
                mk[j][i] = 0;
              end
            end
          end
          mprq[j][i] = q;
          mplv[j][i] = mlvl[j][i];
        end
      end
    end
  endtask
  task automatic step(input logic [1:0] k, input logic r);
    kin = k;
    rst = r;
    @(posedge clk);
    #1;
    cyc++;
    model_step(k, r);
    chk("model_out_a", ia.Key_Out, eout[0]);
    chk("model_lvl_a", ia.Key_Level, elvl[0]);
    chk("model_out_b", ib.Key_Out, eout[1]);
    chk("model_lvl_b", ib.Key_Level, elvl[1]);
  endtask
  task automatic idle(input int n);
    repeat (n) step(2'b11, 1'b0);
  endtask
  typedef struct {
    logic [1:0] k;
    logic r;
    int n;
    int inc;
    int dec;
    logic [1:0] lvl;
  } vec_t;
  vec_t tbl[14];
  initial begin
    tbl[0] = '{2'b11, 1'b0, 10, 0, 0, 2'b00};
    tbl[1] = '{2'b01, 1'b0, 12, 1, 0, 2'b10};
    tbl[2] = '{2'b11, 1'b0, 10, 0, 0, 2'b00};
    tbl[3] = '{2'b10, 1'b0, 12, 0, 1, 2'b01};
    tbl[4] = '{2'b11, 1'b0, 10, 0, 0, 2'b00};
    tbl[5] = '{2'b01, 1'b0, 3, 0, 0, 2'b00};
    tbl[6] = '{2'b11, 1'b0, 10, 0, 0, 2'b00};
    tbl[7] = '{2'b00, 1'b0, 12, 0, 0, 2'b11};
    tbl[8] = '{2'b11, 1'b0, 10, 0, 0, 2'b00};
    tbl[9] = '{2'b01, 1'b0, 30, 2, 0, 2'b10};
    tbl[10] = '{2'b11, 1'b0, 10, 0, 0, 2'b00};
    tbl[11] = '{2'b01, 1'b0, 8, 1, 0, 2'b10};
    tbl[12] = '{2'b11, 1'b1, 1, 0, 0, 2'b00};
    tbl[13] = '{2'b11, 1'b0, 10, 0, 0, 2'b00};
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    chk("reset_out", ia.Key_Out, 2'b00);
    chk("reset_lvl", ia.Key_Level, 2'b00);
    idle(3);
    // Clean increment press and release.
    for (int c = 1; c <= 30; c++) begin
      step(c <= 10 ? 2'b01 : 2'b11, 1'b0);
      chk("clean_out", ia.Key_Out, c == 7 ? 2'b10 : 2'b00);
      chk("clean_lvl", ia.Key_Level, (c >= 7 && c <= 16) ? 2'b10 : 2'b00);
    end
    idle(5);
    // Bouncing decrement key, then stable low.
    for (int c = 1; c <= 40; c++) begin
      logic low;
      low = (c <= 20) ? (((c - 1) / 2) % 2 == 0) : (c <= 30);
      step({1'b1, ~low}, 1'b0);
      chk("bounce_out", ia.Key_Out, c == 27 ? 2'b01 : 2'b00);
    end
    idle(10);
    // Auto-repeat while held.
    for (int c = 1; c <= 70; c++) begin
      step(c <= 60 ? 2'b01 : 2'b11, 1'b0);
      chk("repeat_out", ia.Key_Out,
          (c == 7 || c == 27 || c == 35 || c == 43 || c == 51 || c == 59) ? 2'b10 : 2'b00);
    end
    idle(10);
    // Both keys together.
    for (int c = 1; c <= 45; c++) begin
      step(c <= 40 ? 2'b00 : 2'b11, 1'b0);
      chk("simul_out", ia.Key_Out, 2'b00);
      if (c <= 40) chk("simul_lvl", ia.Key_Level, c >= 7 ? 2'b11 : 2'b00);
    end
    idle(10);
    // Reset pulse while held.
    for (int c = 1; c <= 25; c++) begin
      step(2'b01, c == 10);
      chk("rst_out", ia.Key_Out, (c == 7 || c == 17) ? 2'b10 : 2'b00);
      chk("rst_lvl", ia.Key_Level, ((c >= 7 && c < 10) || c >= 17) ? 2'b10 : 2'b00);
    end
    idle(15);
    // Single-shot instance: long hold with a short release glitch.
    for (int c = 1; c <= 70; c++) begin
      step((c <= 30 || (c >= 34 && c <= 60)) ? 2'b01 : 2'b11, 1'b0);
      chk("noreps_out", ib.Key_Out, c == 7 ? 2'b10 : 2'b00);
    end
    idle(10);
    for (int v = 0; v < 14; v++) begin
      int ninc, ndec;
      ninc = 0;
      ndec = 0;
      for (int c = 0; c < tbl[v].n; c++) begin
        step(tbl[v].k, tbl[v].r);
        if (ia.Key_Out == 2'b10) ninc++;
        if (ia.Key_Out == 2'b01) ndec++;
      end
      chk($sformatf("vec%0d_inc", v), ninc, tbl[v].inc);
      chk($sformatf("vec%0d_dec", v), ndec, tbl[v].dec);
      chk($sformatf("vec%0d_lvl", v), ia.Key_Level, tbl[v].lvl);
    end
    for (int n = 0; n < 150; n++) begin
      logic [1:0] k;
      int len;
      k = 2'($urandom);
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 30) == 0) step(k, 1'b1);
      repeat (len) step(k, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
